// File: rtl/cic_sample_fifo.sv
// Offset-correcting, saturating sample stage feeding a first-word-fall-through FIFO.
// Optional 4-sample block averager enabled by defining CIC_SAMPLE_AVG4_EN.
module cic_sample_fifo #(
    parameter int NUMBITS    = 25,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUMBITS-1:0] cic_in,
    input  logic               cic_valid,
    input  logic [NUMBITS-1:0] offset,
    output logic [NUMBITS-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [AW:0]        fifo_count,
    output logic               overflow,
    input  logic               clear_overflow
);

    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [NUMBITS:0]   diff_wide;
    logic [NUMBITS-1:0] diff_sat;
    logic [NUMBITS-1:0] diff_reg;
    logic               s1_valid;
    logic               push;
    logic [NUMBITS-1:0] push_data;

    assign diff_wide = {1'b0, cic_in} - {1'b0, offset};

    // Both operands are unsigned, so the result only leaves range when the top two bits disagree.
    always_comb begin
        diff_sat = diff_wide[NUMBITS-1:0];
        if (diff_wide[NUMBITS] != diff_wide[NUMBITS-1])
            diff_sat = diff_wide[NUMBITS] ? {1'b1, {(NUMBITS-1){1'b0}}}
                                          : {1'b0, {(NUMBITS-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            diff_reg <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= cic_valid;
            if (cic_valid)
                diff_reg <= diff_sat;
        end
    end

`ifdef CIC_SAMPLE_AVG4_EN
    logic [NUMBITS+1:0] avg_sum;
    logic [NUMBITS+1:0] avg_total;
    logic [1:0]         avg_phase;

    // The 4th sample is folded in combinationally so the push keeps the 2-cycle latency.
    assign avg_total = avg_sum + {{2{diff_reg[NUMBITS-1]}}, diff_reg};
    assign push      = s1_valid && (avg_phase == 2'd3);
    assign push_data = avg_total[NUMBITS+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            avg_sum   <= '0;
            avg_phase <= 2'd0;
        end else if (s1_valid) begin
            avg_phase <= avg_phase + 2'd1;
            avg_sum   <= (avg_phase == 2'd3) ? '0 : avg_total;
        end
    end
`else
    assign push      = s1_valid;
    assign push_data = diff_reg;
`endif

    logic [NUMBITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               pop;
    logic               do_push;
    logic               drop;

    assign full       = (fifo_count == FULL_CNT);
    assign dout_valid = (fifo_count != '0);
    assign pop        = dout_valid && dout_ready;
    assign do_push    = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!reset && do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clear_overflow)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cic_sample_fifo.sv
// Directed bench for cic_sample_fifo in its default build (averager disabled).
module tb_cic_sample_fifo;
    localparam int NB = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] cic_in;
    logic          cic_valid;
    logic [NB-1:0] offset;
    logic [NB-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [3:0]    fifo_count;
    logic          overflow;
    logic          clear_overflow;

    int checks = 0;
    int passes = 0;

    cic_sample_fifo #(.NUMBITS(NB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .cic_in(cic_in), .cic_valid(cic_valid),
        .offset(offset), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .fifo_count(fifo_count), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0] cin;
        logic [NB-1:0] off;
        logic [NB-1:0] expd;
    } vec_t;

    vec_t vecs [9];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv)
            passes++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    initial begin
        vecs[0] = '{cin: 25'h0800000, off: 25'h0800000, expd: 25'h0000000};
        vecs[1] = '{cin: 25'h0000000, off: 25'h1FFFFFF, expd: 25'h1000000};
        vecs[2] = '{cin: 25'h1FFFFFF, off: 25'h0000000, expd: 25'h0FFFFFF};
        vecs[3] = '{cin: 25'd100,     off: 25'd30,      expd: 25'd70};
        vecs[4] = '{cin: 25'd30,      off: 25'd100,     expd: 25'h1FFFFBA};
        vecs[5] = '{cin: 25'h0FFFFFF, off: 25'h0000000, expd: 25'h0FFFFFF};
        vecs[6] = '{cin: 25'h1000000, off: 25'h0000000, expd: 25'h0FFFFFF};
        vecs[7] = '{cin: 25'h0000000, off: 25'h1000000, expd: 25'h1000000};
        vecs[8] = '{cin: 25'h0000000, off: 25'h1000001, expd: 25'h1000000};

        reset = 1'b1; cic_in = '0; cic_valid = 1'b0; offset = '0;
        dout_ready = 1'b0; clear_overflow = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        foreach (vecs[i]) begin
            cic_in = vecs[i].cin; offset = vecs[i].off; cic_valid = 1'b1;
            cyc();
            cic_valid = 1'b0;
            check($sformatf("v%0d_valid_at1", i), 32'(dout_valid), 32'd0);
            cyc();
            check($sformatf("v%0d_valid_at2", i), 32'(dout_valid), 32'd1);
            check($sformatf("v%0d_dout", i), 32'(dout), 32'(vecs[i].expd));
            dout_ready = 1'b1;
            cyc();
            dout_ready = 1'b0;
            check($sformatf("v%0d_empty", i), 32'(dout_valid), 32'd0);
        end

        // Nine strobes into an 8-deep FIFO with the consumer stalled.
        offset = '0;
        for (int i = 1; i <= 9; i++) begin
            cic_in = NB'(i); cic_valid = 1'b1;
            cyc();
        end
        cic_valid = 1'b0;
        cyc();
        check("ovf9_count", 32'(fifo_count), 32'd8);
        check("ovf9_flag", 32'(overflow), 32'd1);
        check("ovf9_head", 32'(dout), 32'd1);
        cyc();
        check("ovf9_hold", 32'(dout), 32'd1);
        dout_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain_valid%0d", k), 32'(dout_valid), 32'd1);
            check($sformatf("drain_dout%0d", k), 32'(dout), 32'(k));
            cyc();
        end
        check("drain_empty", 32'(dout_valid), 32'd0);
        cyc();
        check("ready_when_empty", 32'(fifo_count), 32'd0);
        dout_ready = 1'b0;
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Full FIFO: push with simultaneous pop, then clear colliding with a drop.
        for (int i = 1; i <= 9; i++) begin
            cic_in = NB'(i); cic_valid = 1'b1;
            cyc();
        end
        cic_valid = 1'b0;
        dout_ready = 1'b1;
        cyc();
        dout_ready = 1'b0;
        check("full_pp_count", 32'(fifo_count), 32'd8);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_head", 32'(dout), 32'd2);
        cic_in = NB'(10); cic_valid = 1'b1;
        cyc();
        cic_valid = 1'b0;
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        check("set_wins_ovf", 32'(overflow), 32'd1);
        check("set_wins_count", 32'(fifo_count), 32'd8);
        dout_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            check($sformatf("wrap_dout%0d", k), 32'(dout), 32'(k));
            cyc();
        end
        dout_ready = 1'b0;
        check("wrap_empty", 32'(fifo_count), 32'd0);
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;

        // Reset with 5 stored entries and one sample still in flight.
        for (int i = 1; i <= 5; i++) begin
            cic_in = NB'(i); cic_valid = 1'b1;
            cyc();
        end
        cic_valid = 1'b0;
        cyc();
        check("pre_rst_count", 32'(fifo_count), 32'd5);
        cic_in = NB'(77); cic_valid = 1'b1;
        cyc();
        cic_valid = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_valid", 32'(dout_valid), 32'd0);
        check("mid_rst_dout", 32'(dout), 32'd0);
        cyc();
        check("mid_rst_inflight", 32'(fifo_count), 32'd0);
        cic_in = NB'(42); cic_valid = 1'b1;
        cyc();
        cic_valid = 1'b0;
        check("post_rst_at1", 32'(dout_valid), 32'd0);
        cyc();
        check("post_rst_at2", 32'(dout_valid), 32'd1);
        check("post_rst_dout", 32'(dout), 32'd42);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
